// File: rtl/lift_position_tracker.sv
// lift_position_tracker
//   Tracks the car position from one raw landing-zone sensor. The sensor
//   is synchronised, debounced and turned into rise/fall events. Each
//   event is combined with the controller's own motion and direction to
//   step a floor index. The block drives a one-hot floor vector and a
//   sticky fault flag.
//
// Parameters
//   N_FLOORS         number of floors (>= 2)
//   DEBOUNCE_CYCLES  consecutive synchronised samples required before a
//                    sensor level change is accepted (>= 1)
//
// Ports
//   clk               system clock
//   reset             asynchronous, active-high reset
//   i_motion          car moving
//   i_direction       1 = up, 0 = down
//   i_landing_sensor  raw asynchronous sensor, high inside a landing zone
//   o_flr_pos         one-hot current floor while in a landing zone, else 0
//   o_flr_idx         binary index of the last floor reached
//   o_at_floor        car is parked in or passing through a landing zone
//   o_fault           sticky position-sequence error
module lift_position_tracker #(
   parameter int N_FLOORS        = 12,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        i_motion,
   input  logic                        i_direction,
   input  logic                        i_landing_sensor,
   output logic [N_FLOORS-1:0]         o_flr_pos,
   output logic [$clog2(N_FLOORS)-1:0] o_flr_idx,
   output logic                        o_at_floor,
   output logic                        o_fault
);

   localparam int IDX_W = $clog2(N_FLOORS);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N_FLOORS - 1);

   typedef enum logic [1:0] {
      AT_FLR,
      BETWEEN,
      FAULT
   } state_t;

   logic             s1, s2;
   logic             filt;
   logic [CNT_W-1:0] cnt;
   logic             evt, rise, fall;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             dep_dir_q, dep_dir_d;

   // The car is parked at floor 0 at reset, so the synchroniser starts high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= i_landing_sensor;
         s2 <= s1;
      end
   end

   // A level change is accepted only after DEBOUNCE_CYCLES consecutive
   // differing samples. Any sample that agrees with filt restarts the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt <= 1'b1;
         cnt  <= '0;
      end else if (s2 != filt) begin
         if (cnt == CNT_LAST) begin
            filt <= s2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end else begin
         cnt <= '0;
      end
   end

   assign evt  = (s2 != filt) && (cnt == CNT_LAST);
   assign rise = evt & s2;
   assign fall = evt & ~s2;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      dep_dir_d = dep_dir_q;
      case (state_q)
         AT_FLR: begin
            if (fall) begin
               if (i_motion) begin
                  dep_dir_d = i_direction;
                  state_d   = BETWEEN;
               end else begin
                  state_d = FAULT;
               end
            end
         end
         BETWEEN: begin
            // Motion is not checked here: the car may coast into the zone
            // while it is stopping.
            if (rise) begin
               if (i_direction != dep_dir_q) begin
                  // The car reversed mid-travel and returned to the departure floor.
                  state_d = AT_FLR;
               end else if (i_direction) begin
                  if (idx_q == IDX_TOP) begin
                     state_d = FAULT;
                  end else begin
                     idx_d   = idx_q + IDX_W'(1);
                     state_d = AT_FLR;
                  end
               end else begin
                  if (idx_q == '0) begin
                     state_d = FAULT;
                  end else begin
                     idx_d   = idx_q - IDX_W'(1);
                     state_d = AT_FLR;
                  end
               end
            end
         end
         FAULT:   state_d = FAULT;
         default: state_d = FAULT;
      endcase
   end

   // The outputs are registered from the next-state values. This makes
   // them change on the same edge as the state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= AT_FLR;
         idx_q      <= '0;
         dep_dir_q  <= 1'b0;
         o_flr_pos  <= N_FLOORS'(1);
         o_flr_idx  <= '0;
         o_at_floor <= 1'b1;
         o_fault    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         dep_dir_q  <= dep_dir_d;
         o_flr_pos  <= (state_d == AT_FLR) ? (N_FLOORS'(1) << idx_d) : '0;
         o_flr_idx  <= idx_d;
         o_at_floor <= (state_d == AT_FLR);
         o_fault    <= (state_d == FAULT);
      end
   end

endmodule

// File: tb/tb_lift_position_tracker.sv
module tb_lift_position_tracker;

   localparam int N  = 12;
   localparam int D  = 4;
   localparam int IW = $clog2(N);

   logic          clk = 1'b0;
   logic          reset;
   logic          motion;
   logic          direction;
   logic          sensor;
   logic [N-1:0]  flr_pos;
   logic [IW-1:0] flr_idx;
   logic          at_floor;
   logic          fault;

   int tests_run    = 0;
   int tests_failed = 0;

   lift_position_tracker #(.N_FLOORS(N), .DEBOUNCE_CYCLES(D)) dut (
      .clk              (clk),
      .reset            (reset),
      .i_motion         (motion),
      .i_direction      (direction),
      .i_landing_sensor (sensor),
      .o_flr_pos        (flr_pos),
      .o_flr_idx        (flr_idx),
      .o_at_floor       (at_floor),
      .o_fault          (fault)
   );

   always #5 clk = ~clk;

   // Reference model. mode: 0 parked at a floor, 1 travelling, 2 faulted.
   int m_floor;
   int m_mode;
   bit m_dep;
   bit m_level;
   int m_run;
   bit m_delay[$];

   task automatic model_reset();
      m_floor = 0;
      m_mode  = 0;
      m_dep   = 1'b0;
      m_level = 1'b1;
      m_run   = 0;
      m_delay = {1'b1, 1'b1};
   endtask

   task automatic model_event(input bit entered_zone);
      int target;
      if (m_mode == 0 && !entered_zone) begin
         if (motion) begin
            m_dep  = direction;
            m_mode = 1;
         end else begin
            m_mode = 2;
         end
      end else if (m_mode == 1 && entered_zone) begin
         if (direction != m_dep) begin
            m_mode = 0;
         end else begin
            target = direction ? m_floor + 1 : m_floor - 1;
            if (target < 0 || target >= N) m_mode = 2;
            else begin
               m_floor = target;
               m_mode  = 0;
            end
         end
      end
   endtask

   // The sensor reaches the debouncer two samples late. A new level counts
   // once it has been seen D times in a row.
   task automatic model_edge();
      bit seen;
      seen = m_delay[0];
      void'(m_delay.pop_front());
      m_delay.push_back(sensor);
      if (seen != m_level) begin
         m_run++;
         if (m_run == D) begin
            m_level = seen;
            m_run   = 0;
            model_event(seen);
         end
      end else begin
         m_run = 0;
      end
   endtask

   function automatic logic [N-1:0] exp_pos();
      return (m_mode == 0) ? (N'(1) << m_floor) : '0;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("flr_pos",  64'(flr_pos),  64'(exp_pos()));
      check("flr_idx",  64'(flr_idx),  64'(m_floor));
      check("at_floor", 64'(at_floor), 64'(m_mode == 0));
      check("fault",    64'(fault),    64'(m_mode == 2));
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic trip(input int low, input int high);
      sensor = 1'b0;
      steps(low);
      sensor = 1'b1;
      steps(high);
   endtask

   task automatic do_reset();
      sensor = 1'b0;
      reset  = 1'b1;
      #2;
      check("rst_pos",  64'(flr_pos),  64'h001);
      check("rst_idx",  64'(flr_idx),  64'd0);
      check("rst_atf",  64'(at_floor), 64'd1);
      check("rst_flt",  64'(fault),    64'd0);
      sensor = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   int lat;

   initial begin
      reset     = 1'b0;
      motion    = 1'b1;
      direction = 1'b1;
      sensor    = 1'b1;
      #3;
      do_reset();
      steps(10);
      check("post_rst_pos", 64'(flr_pos), 64'h001);

      // Up travel: three floors. Measure the edge latency of each output change.
      for (int t = 0; t < 3; t++) begin
         sensor = 1'b0;
         lat = 0;
         for (int i = 1; i <= 20; i++) begin
            step();
            if (lat == 0 && flr_pos == '0) lat = i;
         end
         check("fall_latency", 64'(lat), 64'd6);
         sensor = 1'b1;
         lat = 0;
         for (int i = 1; i <= 20; i++) begin
            step();
            if (lat == 0 && flr_pos != '0) lat = i;
         end
         check("rise_latency", 64'(lat), 64'd6);
         check("up_pos", 64'(flr_pos), 64'(N'(2) << t));
      end
      check("up_idx", 64'(flr_idx), 64'd3);

      trip($urandom_range(8, 30), $urandom_range(8, 30));
      trip($urandom_range(8, 30), $urandom_range(8, 30));
      check("floor5_pos", 64'(flr_pos), 64'h020);

      // Glitch rejection: the fixed 3-cycle drop, then random sub-threshold drops.
      trip(3, 10);
      check("glitch_pos", 64'(flr_pos), 64'h020);
      check("glitch_atf", 64'(at_floor), 64'd1);
      for (int g = 0; g < 4; g++) trip($urandom_range(1, D - 1), $urandom_range(1, 6));
      steps(8);

      // Reversal mid-travel.
      direction = 1'b1;
      sensor = 1'b0;
      steps(15);
      direction = 1'b0;
      steps(5);
      sensor = 1'b1;
      steps(10);
      check("rev_pos", 64'(flr_pos), 64'h020);
      check("rev_idx", 64'(flr_idx), 64'd5);

      // Travel to the top floor, then try to go past it.
      direction = 1'b1;
      repeat (6) trip($urandom_range(8, 25), $urandom_range(8, 25));
      check("top_idx", 64'(flr_idx), 64'd11);
      trip(20, 20);
      check("top_fault", 64'(fault), 64'd1);
      check("top_pos", 64'(flr_pos), 64'h000);
      repeat (3) trip(15, 15);
      check("top_fault_sticky", 64'(fault), 64'd1);
      check("top_idx_frozen", 64'(flr_idx), 64'd11);

      // Go below floor 0.
      do_reset();
      motion    = 1'b1;
      direction = 1'b0;
      trip(20, 20);
      check("bot_fault", 64'(fault), 64'd1);
      check("bot_pos", 64'(flr_pos), 64'h000);
      repeat (2) trip(15, 15);
      check("bot_fault_sticky", 64'(fault), 64'd1);

      // Departure without motion.
      do_reset();
      direction = 1'b1;
      trip(20, 20);
      trip(20, 20);
      check("f2_pos", 64'(flr_pos), 64'h004);
      motion = 1'b0;
      sensor = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (lat == 0 && fault) lat = i;
      end
      check("motionless_latency", 64'(lat), 64'd6);
      sensor = 1'b1;
      steps(10);
      check("motionless_fault", 64'(fault), 64'd1);

      // Random trips, with random direction flips, glitch-length drops and
      // occasional motionless departures.
      do_reset();
      for (int r = 0; r < 40; r++) begin
         if (m_mode == 2) do_reset();
         motion    = ($urandom_range(0, 9) != 0);
         direction = $urandom_range(0, 1);
         sensor    = 1'b0;
         steps($urandom_range(1, 25));
         if ($urandom_range(0, 3) == 0) direction = ~direction;
         motion = $urandom_range(0, 1);
         sensor = 1'b1;
         steps($urandom_range(1, 25));
      end
      steps(10);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
